fuzz_datapath_top: RTL and testbench
====================================

Name: fuzz_datapath_top

Overview:
- Mixed register/combinational datapath. It folds four narrow operand buses into one 246-bit status word `y`.
- Used as a synthesis/simulation cross-check block: every output bit is deterministic from reset and the input history.
- Fields are packed LSB-first. Registered fields update on the rising edge of `clk`; combinational fields follow the inputs directly.

Parameters:
- None. All widths are fixed.

Ports:
- clk    input   1    system clock, rising edge
- rst    input   1    asynchronous, active-high reset
- wire0  input   12   unsigned operand A
- wire1  input   7    unsigned operand B
- wire2  input   17   signed (two's complement) operand C
- wire3  input   7    unsigned operand D
- y      output  246  packed result word, y[245:0]

Behaviour:
- Reset:
  - rst high clears every register immediately, independent of clk.
  - Exceptions: LFSR resets to 32'h0000_0001; running max resets to 17'h10000 (-65536).
  - Combinational fields are unaffected by reset.
  - Deassertion is sampled synchronously; the first update is on the first rising edge with rst low.
- Registered fields (1-cycle latency, sampled at the rising edge):
  - y[11:0]    = wire0 ^ {wire1[4:0], wire3}
  - y[28:12]   = wire2 + signed {1'b0, wire0}, 17-bit wrap
  - y[35:29]   = wire1 & ~wire3
  - y[49:36]   = wire1 * wire3, unsigned, 14 bits
  - y[50]      = XOR-reduction of all 43 input bits
  - y[51]      = wire2 < 0 (signed)
  - y[52]      = (wire0 == {wire3[4:0], wire1})
  - y[53+:16]  = free-running counter, +1 per edge, wraps at 16'hFFFF->0
  - y[69+:32]  = accumulator; acc <= acc + sign-extended wire2, wraps at 32 bits
  - y[101+:32] = LFSR: next = {lfsr[30:0], fb}, fb = lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]^(^wire0)
  - y[133+:43] = {wire3, wire2, wire1, wire0} delayed through two register stages (2-cycle latency)
  - y[205+:17] = running signed max of wire2 since reset; ties keep the stored value
  - y[222+:6]  = popcount of all 43 input bits (0..43)
  - y[228+:18] = signed 18-bit: sext(wire2) - {1'b0, wire1, wire3}; never overflows
- Combinational fields (0 latency):
  - y[176+:17] = wire2 >>> wire3[3:0], arithmetic shift
  - y[193+:12] = wire0 rotated left by (wire1[3:0] mod 12); shift amounts 12..15 map to 0..3
- Simultaneous rst and clk edge: reset wins.
- No X propagation from reset onward; there are no undriven bits.

Optional Feature:
- Macro SATURATE_ACC_EN.
- Defined: the accumulator saturates at 32'h7FFF_FFFF and 32'h8000_0000 instead of wrapping; once saturated, it moves back only when an addend of the opposite sign arrives.
- Undefined: plain two's-complement wrap, as specified above.

Test Plan:
- Reset: assert rst with all inputs 0.
  - Registered bits all 0 except y[101+:32]=1 and y[205+:17]=17'h10000.
  - y[176+:17]=0 and y[193+:12]=0.
- Single vector after reset: wire0=12'h0F0, wire1=7'h03, wire2=17'h1FFFF, wire3=7'h05, one edge.
  - Registered: y[28:12]=17'h000EF, y[49:36]=15, y[51]=1, y[228+:18]=-390.
  - Combinational: y[176+:17]=17'h1FFFF, y[193+:12]=12'h780.
- Accumulate/count: wire2=100 held for 3 edges after reset -> acc=300, counter=3, max=100.
  - Then wire2=-5 for 1 edge -> acc=295, max stays 100.
- Delay line: vector V applied before edge n, then changed -> y[133+:43]=V after edge n+1 and not after edge n.
- Rotate wrap: wire0=12'h801, wire1[3:0]=13 -> y[193+:12]=12'h003.
  - Same with wire1[3:0]=12 -> 12'h801.
- Async reset mid-run: pulse rst between clock edges after 5 active cycles -> counter and acc read 0 before the next clk edge.
  - With SATURATE_ACC_EN defined: 32'h7FFF_FF00 accumulated with +1000 holds 32'h7FFF_FFFF.

Source files
------------

// File: rtl/fuzz_datapath_top.sv
// Mixed registered/combinational datapath that folds four operand buses into a 246-bit status word.
// Build macro SATURATE_ACC_EN: the accumulator saturates instead of wrapping (default: wrap).
module fuzz_datapath_top (
   input  logic         clk,
   input  logic         rst,
   input  logic [11:0]  wire0,
   input  logic [6:0]   wire1,
   input  logic [16:0]  wire2,
   input  logic [6:0]   wire3,
   output logic [245:0] y
);

   localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
   localparam logic [16:0] MAX_INIT  = 17'h10000;

   logic [42:0] in_vec;
   logic [31:0] addend;

   assign in_vec = {wire3, wire2, wire1, wire0};
   assign addend = {{15{wire2[16]}}, wire2};

   // Next-state values for the registered fields
   logic [11:0] xor_d;
   logic [16:0] sum_d;
   logic [6:0]  and_d;
   logic [13:0] mul_d;
   logic        par_d;
   logic        neg_d;
   logic        eq_d;
   logic [15:0] cnt_d;
   logic [31:0] acc_d;
   logic [31:0] lfsr_d;
   logic [16:0] max_d;
   logic [5:0]  pop_d;
   logic [17:0] diff_d;

   // Register state
   logic [11:0] xor_q;
   logic [16:0] sum_q;
   logic [6:0]  and_q;
   logic [13:0] mul_q;
   logic        par_q;
   logic        neg_q;
   logic        eq_q;
   logic [15:0] cnt_q;
   logic [31:0] acc_q;
   logic [31:0] lfsr_q;
   logic [42:0] dly1_q;
   logic [42:0] dly2_q;
   logic [16:0] max_q;
   logic [5:0]  pop_q;
   logic [17:0] diff_q;

   // Combinational fields
   logic [16:0] shr;
   logic [3:0]  rot_amt;
   logic [11:0] rot;

   assign xor_d  = wire0 ^ {wire1[4:0], wire3};
   assign sum_d  = wire2 + {5'b0_0000, wire0};
   assign and_d  = wire1 & ~wire3;
   assign mul_d  = {7'b000_0000, wire1} * {7'b000_0000, wire3};
   assign par_d  = ^in_vec;
   assign neg_d  = wire2[16];
   assign eq_d   = (wire0 == {wire3[4:0], wire1});
   assign cnt_d  = cnt_q + 16'd1;
   assign lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0] ^ (^wire0)};
   assign max_d  = ($signed(wire2) > $signed(max_q)) ? wire2 : max_q;
   // Modulo-2^18 subtraction equals the signed result because it cannot overflow
   assign diff_d = {wire2[16], wire2} - {3'b000, wire1, wire3};

   always_comb begin
      // NOTE: give every always_comb output a default before any loop or branch so no latch is inferred.
      pop_d = '0;
      for (int i = 0; i < 43; i++) begin
         pop_d = pop_d + {5'b0_0000, in_vec[i]};
      end
   end

`ifdef SATURATE_ACC_EN
   logic [32:0] acc_sum;

   always_comb begin
      acc_sum = {acc_q[31], acc_q} + {addend[31], addend};
      acc_d   = acc_sum[31:0];
      if (acc_sum[32] != acc_sum[31]) begin
         acc_d = acc_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end
`else
   assign acc_d = acc_q + addend;
`endif

   assign shr     = $signed(wire2) >>> wire3[3:0];
   assign rot_amt = (wire1[3:0] >= 4'd12) ? (wire1[3:0] - 4'd12) : wire1[3:0];
   assign rot     = (wire0 << rot_amt) | (wire0 >> (4'd12 - rot_amt));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xor_q  <= '0;
         sum_q  <= '0;
         and_q  <= '0;
         mul_q  <= '0;
         par_q  <= 1'b0;
         neg_q  <= 1'b0;
         eq_q   <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         lfsr_q <= LFSR_SEED;
         dly1_q <= '0;
         dly2_q <= '0;
         max_q  <= MAX_INIT;
         pop_q  <= '0;
         diff_q <= '0;
      end else begin
         xor_q  <= xor_d;
         sum_q  <= sum_d;
         and_q  <= and_d;
         mul_q  <= mul_d;
         par_q  <= par_d;
         neg_q  <= neg_d;
         eq_q   <= eq_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         lfsr_q <= lfsr_d;
         dly1_q <= in_vec;
         dly2_q <= dly1_q;
         max_q  <= max_d;
         pop_q  <= pop_d;
         diff_q <= diff_d;
      end
   end

   assign y = {diff_q, pop_q, max_q, rot, shr, dly2_q, lfsr_q, acc_q, cnt_q,
               eq_q, neg_q, par_q, mul_q, and_q, sum_q, xor_q};

endmodule

// File: tb/tb_fuzz_datapath_top.sv
// Scoreboard bench for fuzz_datapath_top: a reference model predicts y each cycle, a negedge monitor compares.
// Honours SATURATE_ACC_EN the same way as the design.
module tb_fuzz_datapath_top;

   logic         clk = 1'b0;
   logic         rst;
   logic [11:0]  wire0;
   logic [6:0]   wire1;
   logic [16:0]  wire2;
   logic [6:0]   wire3;
   logic [245:0] y;

   fuzz_datapath_top dut (
      .clk   (clk),
      .rst   (rst),
      .wire0 (wire0),
      .wire1 (wire1),
      .wire2 (wire2),
      .wire3 (wire3),
      .y     (y)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [245:0] exp_q[$];

   // Reference model state
   bit          m_valid;
   logic [11:0] m_w0;
   logic [6:0]  m_w1;
   logic [16:0] m_w2;
   logic [6:0]  m_w3;
   int          m_cnt;
   logic [31:0] m_acc;
   logic [31:0] m_lfsr;
   int          m_max;
   logic [42:0] m_hist[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sext17(input logic [16:0] v);
      return v[16] ? int'(v) - 131072 : int'(v);
   endfunction

   function automatic logic [63:0] fld(input int l, input int w);
      return 64'(y >> l) & ((64'd1 << w) - 64'd1);
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_w0 = '0; m_w1 = '0; m_w2 = '0; m_w3 = '0;
      m_cnt  = 0;
      m_acc  = 32'd0;
      m_lfsr = 32'd1;
      m_max  = -65536;
      m_hist = '{43'd0, 43'd0};
   endtask

   // Advance the model by one active clock edge using the inputs present at that edge
   task automatic model_edge();
      int     s;
      longint t;
      s = sext17(wire2);
      m_hist.push_back({wire3, wire2, wire1, wire0});
      void'(m_hist.pop_front());
      m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0] ^ (^wire0)};
      m_cnt  = (m_cnt + 1) % 65536;
`ifdef SATURATE_ACC_EN
      t = longint'($signed(m_acc)) + longint'(s);
      if (t > 64'sd2147483647) t = 64'sd2147483647;
      if (t < -64'sd2147483648) t = -64'sd2147483648;
      m_acc = 32'(t);
`else
      t = longint'(m_acc) + longint'(s);
      m_acc = 32'(t);
`endif
      if (s > m_max) m_max = s;
      m_valid = 1'b1;
      m_w0 = wire0; m_w1 = wire1; m_w2 = wire2; m_w3 = wire3;
   endtask

   function automatic logic [245:0] predict();
      logic [245:0] e;
      logic [42:0]  v;
      int           s;
      int           amt;
      e = '0;
      if (m_valid) begin
         s = sext17(m_w2);
         v = {m_w3, m_w2, m_w1, m_w0};
         e[11:0]    = 12'(int'(m_w0) ^ ((int'(m_w1) % 32) * 128 + int'(m_w3)));
         e[28:12]   = 17'(s + int'(m_w0));
         e[35:29]   = 7'(int'(m_w1) & (127 - int'(m_w3)));
         e[49:36]   = 14'(int'(m_w1) * int'(m_w3));
         e[50]      = ($countones(v) % 2) == 1;
         e[51]      = s < 0;
         e[52]      = int'(m_w0) == (int'(m_w3) % 32) * 128 + int'(m_w1);
         e[222 +: 6]  = 6'($countones(v));
         e[228 +: 18] = 18'(s - (int'(m_w1) * 128 + int'(m_w3)));
      end
      e[53 +: 16]  = 16'(m_cnt);
      e[69 +: 32]  = m_acc;
      e[101 +: 32] = m_lfsr;
      e[133 +: 43] = m_hist[0];
      e[205 +: 17] = 17'(m_max);
      s   = sext17(wire2);
      amt = int'(wire1[3:0]) % 12;
      e[176 +: 17] = 17'(s >>> int'(wire3[3:0]));
      e[193 +: 12] = 12'((int'(wire0) << amt) | (int'(wire0) >> (12 - amt)));
      return e;
   endfunction

   // One clock cycle: let the edge happen, then apply new inputs and queue the expected word
   task automatic step(input logic r, input logic [11:0] a, input logic [6:0] b,
                       input logic [16:0] c, input logic [6:0] d);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      rst = r; wire0 = a; wire1 = b; wire2 = c; wire3 = d;
      if (r) model_reset();
      exp_q.push_back(predict());
   endtask

   // Edge with current inputs, then an asynchronous reset pulse well before the next edge
   task automatic mid_reset();
      @(posedge clk);
      if (!rst) model_edge();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      rst = 1'b0;
      exp_q.push_back(predict());
   endtask

   task automatic rand_step();
      logic [11:0] a;
      logic [6:0]  b;
      logic [16:0] c;
      logic [6:0]  d;
      a = 12'($urandom);
      b = 7'($urandom);
      d = 7'($urandom);
      case ($urandom_range(0, 3))
         0:       c = 17'h10000;
         1:       c = 17'h0FFFF;
         default: c = 17'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) a = {d[4:0], b};
      step(1'b0, a, b, c, d);
   endtask

   // Monitor: compare every field of y against the oldest queued expectation
   string       f_name[16] = '{"xor", "sum", "and", "mul", "parity", "neg", "eq", "counter",
                               "acc", "lfsr", "delay", "shr", "rot", "max", "popcount", "diff"};
   int          f_lsb[16]  = '{0, 12, 29, 36, 50, 51, 52, 53, 69, 101, 133, 176, 193, 205, 222, 228};
   int          f_wid[16]  = '{12, 17, 7, 14, 1, 1, 1, 16, 32, 32, 43, 17, 12, 17, 6, 18};
   logic [245:0] mon_exp;

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp = exp_q.pop_front();
         for (int i = 0; i < 16; i++) begin
            check(f_name[i], fld(f_lsb[i], f_wid[i]),
                  64'(mon_exp >> f_lsb[i]) & ((64'd1 << f_wid[i]) - 64'd1));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wire0 = '0; wire1 = '0; wire2 = '0; wire3 = '0;
      model_reset();

      step(1'b1, 12'h000, 7'h00, 17'h00000, 7'h00);
      @(negedge clk);
      check("rst_lfsr", fld(101, 32), 64'h1);
      check("rst_max", fld(205, 17), 64'h10000);
      check("rst_counter", fld(53, 16), 64'h0);
      check("rst_shr", fld(176, 17), 64'h0);
      check("rst_rot", fld(193, 12), 64'h0);

      step(1'b0, 12'h0F0, 7'h03, 17'h1FFFF, 7'h05);
      @(negedge clk);
      check("vec_shr", fld(176, 17), 64'h1FFFF);
      check("vec_rot", fld(193, 12), 64'h780);

      step(1'b0, 12'h000, 7'h00, 17'd100, 7'h00);
      @(negedge clk);
      check("vec_sum", fld(12, 17), 64'h000EF);
      check("vec_mul", fld(36, 14), 64'd15);
      check("vec_neg", fld(51, 1), 64'd1);
      check("vec_diff", fld(228, 18), 64'h3FE7A);

      repeat (3) rand_step();
      step(1'b0, 12'h000, 7'h00, 17'd100, 7'h00);
      mid_reset();
      @(negedge clk);
      check("async_counter", fld(53, 16), 64'h0);
      check("async_acc", fld(69, 32), 64'h0);

      step(1'b0, 12'h000, 7'h00, 17'd100, 7'h00);
      step(1'b0, 12'h000, 7'h00, 17'd100, 7'h00);
      step(1'b0, 12'h000, 7'h00, 17'h1FFFB, 7'h00);
      @(negedge clk);
      check("accum_300", fld(69, 32), 64'd300);
      check("count_3", fld(53, 16), 64'd3);
      check("max_100", fld(205, 17), 64'd100);
      step(1'b0, 12'h000, 7'h00, 17'h00000, 7'h00);
      @(negedge clk);
      check("accum_295", fld(69, 32), 64'd295);
      check("max_keep", fld(205, 17), 64'd100);

      step(1'b0, 12'h801, 7'h0D, 17'h00000, 7'h00);
      @(negedge clk);
      check("rot_13", fld(193, 12), 64'h003);
      step(1'b0, 12'h801, 7'h0C, 17'h00000, 7'h00);
      @(negedge clk);
      check("rot_12", fld(193, 12), 64'h801);

      step(1'b0, 12'h5A5, 7'h55, 17'h1ABCD, 7'h2A);
      step(1'b0, 12'h000, 7'h00, 17'h00000, 7'h00);
      @(negedge clk);
      check("delay_not_yet", fld(133, 43), 64'({7'h00, 17'h00000, 7'h0C, 12'h801}));
      step(1'b0, 12'h000, 7'h00, 17'h00000, 7'h00);
      @(negedge clk);
      check("delay_two", fld(133, 43), 64'({7'h2A, 17'h1ABCD, 7'h55, 12'h5A5}));

`ifdef SATURATE_ACC_EN
      mid_reset();
      repeat (32780) step(1'b0, 12'h000, 7'h00, 17'h0FFFF, 7'h00);
      @(negedge clk);
      check("sat_high", fld(69, 32), 64'h7FFF_FFFF);
      step(1'b0, 12'h000, 7'h00, 17'h1FFFF, 7'h00);
      step(1'b0, 12'h000, 7'h00, 17'h00000, 7'h00);
      @(negedge clk);
      check("sat_release", fld(69, 32), 64'h7FFF_FFFE);
`endif

      repeat (400) begin
         if ($urandom_range(0, 49) == 0) mid_reset();
         else rand_step();
      end

      @(negedge clk);
      #1;
      check("queue_drain", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
